// File: rtl/birdsong_pkg.sv
// Shared constants and types for the birdsong sample scheduler.
package birdsong_pkg;

  localparam int DW            = 16;
  localparam int DEF_CLK_DIV   = 2083;
  localparam int DEF_CHAIN_LAT = 1;

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    WAIT_LAT
  } state_t;

endpackage

// File: rtl/birdsong_tick_gen.sv
// Divide-by-CLK_DIV sample-period counter; held at zero while run is low.
module birdsong_tick_gen
  import birdsong_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!run || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/birdsong_sample_scheduler.sv
// Sample-rate controller feeding birdsong_chain once per CLK_DIV clocks.
// Optional underrun/overrun statistics: define BIRDSONG_SCHED_STATS_EN.
module birdsong_sample_scheduler
  import birdsong_pkg::*;
#(
  parameter int DW        = birdsong_pkg::DW,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int CHAIN_LAT = DEF_CHAIN_LAT,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [DW-1:0] s_data,
  output logic signed [DW-1:0] chain_x,
  output logic                 chain_ce,
  input  logic signed [DW-1:0] chain_y,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW-1:0] m_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     underrun_cnt,
  output logic [CNT_W-1:0]     overrun_cnt
);

  localparam int            LW       = (CHAIN_LAT < 1) ? 1 : $clog2(CHAIN_LAT + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(CHAIN_LAT);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_tick;
  logic                w_run;
  logic                w_accept;
  logic                w_capture;
  logic [LW-1:0]       r_lat;
  logic signed [DW-1:0] r_chain_x;
  logic                r_chain_ce;
  logic                r_m_valid;
  logic signed [DW-1:0] r_m_data;

  assign w_run = (r_state != IDLE);

  birdsong_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A tick wins over en=0 in WAIT_TICK; en is not looked at in WAIT_LAT.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) w_state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (w_tick) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_LAT;
        end else if (!en) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT_LAT: begin
        if (r_lat == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = en ? WAIT_TICK : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain_x  <= '0;
      r_chain_ce <= 1'b0;
      r_lat      <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
    end else begin
      r_chain_ce <= w_accept;
      if (w_accept) begin
        r_chain_x <= s_valid ? s_data : '0;
        r_lat     <= LAT_INIT;
      end else if ((r_state == WAIT_LAT) && (r_lat != '0)) begin
        r_lat <= r_lat - LW'(1);
      end
      if (w_capture) begin
        r_m_valid <= 1'b1;
        r_m_data  <= chain_y;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

`ifdef BIRDSONG_SCHED_STATS_EN
  logic             w_underrun;
  logic             w_overrun;
  logic [CNT_W-1:0] r_underrun_cnt;
  logic [CNT_W-1:0] r_overrun_cnt;

  assign w_underrun = w_accept && !s_valid;
  assign w_overrun  = w_capture && r_m_valid && !m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun_cnt <= '0;
      r_overrun_cnt  <= '0;
    end else begin
      if (w_underrun && (r_underrun_cnt != '1)) r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
      if (w_overrun && (r_overrun_cnt != '1))   r_overrun_cnt  <= r_overrun_cnt + CNT_W'(1);
    end
  end

  assign underrun_cnt = r_underrun_cnt;
  assign overrun_cnt  = r_overrun_cnt;
`else
  assign underrun_cnt = '0;
  assign overrun_cnt  = '0;
`endif

  assign s_ready  = w_accept;
  assign busy     = (r_state == WAIT_LAT);
  assign chain_x  = r_chain_x;
  assign chain_ce = r_chain_ce;
  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;

endmodule

// File: tb/tb_birdsong_sample_scheduler.sv
// Directed bench for birdsong_sample_scheduler with CLK_DIV=8, CHAIN_LAT=3, CNT_W=2.
module tb_birdsong_sample_scheduler;

`ifdef BIRDSONG_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [15:0] chain_x;
  logic        chain_ce;
  logic [15:0] chain_y;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        busy;
  logic [1:0]  underrun_cnt;
  logic [1:0]  overrun_cnt;

  logic [15:0] st1 = '0, st2 = '0, st3 = '0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stub chain: y is the x seen three cycles earlier.
  always @(posedge clk) begin
    st1 <= chain_x;
    st2 <= st1;
    st3 <= st2;
  end
  assign chain_y = st3;

  birdsong_sample_scheduler #(
    .DW        (16),
    .CLK_DIV   (8),
    .CHAIN_LAT (3),
    .CNT_W     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .chain_x      (chain_x),
    .chain_ce     (chain_ce),
    .chain_y      (chain_y),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .busy         (busy),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  typedef struct {
    int cyc;
    int en, sv, sd, mr;
    int sr, ce, mv, bsy, cx, md, und, ovr;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic int exp_cnt(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_sready"}, 32'(s_ready), 0);
    chk({pfx, "_ce"}, 32'(chain_ce), 0);
    chk({pfx, "_cx"}, 32'(chain_x), 0);
    chk({pfx, "_mv"}, 32'(m_valid), 0);
    chk({pfx, "_md"}, 32'(m_data), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_und"}, 32'(underrun_cnt), 0);
    chk({pfx, "_ovr"}, 32'(overrun_cnt), 0);
  endtask

  initial begin
    int cur;
    int n_ce, n_sr, n_mv;
    int seen;
    int ce_at [5];

    //          cyc en sv sd       mr  sr ce mv bsy cx       md       und ovr
    tbl[0]  = '{0,  1, 1, 'h1234, 1,  0, 0, 0, 0, 'h0000, 'h0000, 0, 0};
    tbl[1]  = '{7,  1, 1, 'h1234, 1,  0, 0, 0, 0, 'h0000, 'h0000, 0, 0};
    tbl[2]  = '{8,  1, 1, 'h1234, 1,  1, 0, 0, 0, 'h0000, 'h0000, 0, 0};
    tbl[3]  = '{9,  1, 1, 'h1234, 1,  0, 1, 0, 1, 'h1234, 'h0000, 0, 0};
    tbl[4]  = '{12, 1, 1, 'h1234, 1,  0, 0, 0, 1, 'h1234, 'h0000, 0, 0};
    tbl[5]  = '{13, 1, 1, 'h1234, 1,  0, 0, 1, 0, 'h1234, 'h1234, 0, 0};
    tbl[6]  = '{14, 1, 1, 'h1234, 1,  0, 0, 0, 0, 'h1234, 'h1234, 0, 0};
    tbl[7]  = '{16, 1, 1, 'h1234, 1,  1, 0, 0, 0, 'h1234, 'h1234, 0, 0};
    tbl[8]  = '{17, 1, 1, 'h1234, 1,  0, 1, 0, 1, 'h1234, 'h1234, 0, 0};
    tbl[9]  = '{21, 1, 1, 'h1234, 1,  0, 0, 1, 0, 'h1234, 'h1234, 0, 0};
    tbl[10] = '{24, 1, 0, 'hBEEF, 1,  1, 0, 0, 0, 'h1234, 'h1234, 0, 0};
    tbl[11] = '{25, 1, 1, 'h0001, 1,  0, 1, 0, 1, 'h0000, 'h1234, 1, 0};
    tbl[12] = '{29, 1, 1, 'h0001, 1,  0, 0, 1, 0, 'h0000, 'h0000, 1, 0};
    tbl[13] = '{30, 1, 1, 'h0001, 0,  0, 0, 0, 0, 'h0000, 'h0000, 1, 0};
    tbl[14] = '{32, 1, 1, 'h0001, 0,  1, 0, 0, 0, 'h0000, 'h0000, 1, 0};
    tbl[15] = '{33, 1, 1, 'h0002, 0,  0, 1, 0, 1, 'h0001, 'h0000, 1, 0};
    tbl[16] = '{37, 1, 1, 'h0002, 0,  0, 0, 1, 0, 'h0001, 'h0001, 1, 0};
    tbl[17] = '{41, 1, 1, 'h0003, 0,  0, 1, 1, 1, 'h0002, 'h0001, 1, 0};
    tbl[18] = '{45, 1, 1, 'h0003, 0,  0, 0, 1, 0, 'h0002, 'h0002, 1, 1};
    tbl[19] = '{49, 1, 1, 'h0003, 0,  0, 1, 1, 1, 'h0003, 'h0002, 1, 1};
    tbl[20] = '{53, 1, 1, 'h00AA, 1,  0, 0, 1, 0, 'h0003, 'h0003, 1, 2};
    tbl[21] = '{54, 1, 1, 'h00AA, 1,  0, 0, 0, 0, 'h0003, 'h0003, 1, 2};
    tbl[22] = '{56, 1, 1, 'h00AA, 1,  1, 0, 0, 0, 'h0003, 'h0003, 1, 2};
    tbl[23] = '{57, 0, 1, 'h00AA, 1,  0, 1, 0, 1, 'h00AA, 'h0003, 1, 2};
    tbl[24] = '{61, 0, 1, 'h00AA, 1,  0, 0, 1, 0, 'h00AA, 'h00AA, 1, 2};

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    n_ce = 0;
    n_sr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (chain_ce) n_ce++;
      if (s_ready) n_sr++;
    end
    chk("idle_ce_pulses", n_ce, 0);
    chk("idle_sready_pulses", n_sr, 0);

    // Stream / underrun / overrun / en-drop table
    cur = 0;
    for (int i = 0; i < NV; i++) begin
      while (cur < tbl[i].cyc) begin
        @(negedge clk);
        cur++;
      end
      chk($sformatf("v%0d_sready", i), 32'(s_ready), tbl[i].sr);
      chk($sformatf("v%0d_ce", i), 32'(chain_ce), tbl[i].ce);
      chk($sformatf("v%0d_mvalid", i), 32'(m_valid), tbl[i].mv);
      chk($sformatf("v%0d_busy", i), 32'(busy), tbl[i].bsy);
      chk($sformatf("v%0d_chain_x", i), 32'(chain_x), tbl[i].cx);
      chk($sformatf("v%0d_mdata", i), 32'(m_data), tbl[i].md);
      chk($sformatf("v%0d_underrun", i), 32'(underrun_cnt), exp_cnt(tbl[i].und));
      chk($sformatf("v%0d_overrun", i), 32'(overrun_cnt), exp_cnt(tbl[i].ovr));
      en      = 1'(tbl[i].en);
      s_valid = 1'(tbl[i].sv);
      s_data  = 16'(tbl[i].sd);
      m_ready = 1'(tbl[i].mr);
    end

    // After en dropped mid-sample: FSM idles, no further strobes
    n_ce = 0;
    n_sr = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (chain_ce) n_ce++;
      if (s_ready) n_sr++;
    end
    chk("endrop_ce_pulses", n_ce, 0);
    chk("endrop_sready_pulses", n_sr, 0);
    chk("endrop_mvalid_cleared", 32'(m_valid), 0);
    chk("endrop_chain_x_held", 32'(chain_x), 'h00AA);

    // Reset asserted mid-sample
    s_data  = 16'h5555;
    s_valid = 1'b1;
    m_ready = 1'b0;
    en      = 1'b1;
    seen    = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (chain_ce) seen = 1;
    end
    chk("abort_ce_seen", seen, 1);
    chk("abort_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_ce = 0;
    n_mv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (chain_ce) n_ce++;
      if (m_valid) n_mv++;
    end
    chk("abort_ce_after", n_ce, 0);
    chk("abort_mvalid_after", n_mv, 0);

    // Five underruns into a 2-bit counter; strobe spacing
    s_valid = 1'b0;
    m_ready = 1'b1;
    en      = 1'b1;
    n_ce    = 0;
    for (int i = 0; i < 5; i++) ce_at[i] = 0;
    for (int k = 0; k < 120 && n_ce < 5; k++) begin
      @(negedge clk);
      if (chain_ce) begin
        ce_at[n_ce] = k;
        n_ce++;
      end
    end
    chk("sat_ce_count", n_ce, 5);
    chk("sat_first_ce", ce_at[0], 8);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("sat_ce_spacing%0d", i), ce_at[i] - ce_at[i-1], 8);
    end
    chk("sat_underrun", 32'(underrun_cnt), exp_cnt(3));
    chk("sat_overrun", 32'(overrun_cnt), 0);
    chk("sat_chain_x", 32'(chain_x), 0);
    en = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/birdsong_sample_scheduler.md
# birdsong_sample_scheduler

Sample-rate controller for the birdsong filter chain. It sits between an upstream sample source (valid/ready) and `birdsong_chain`. Every `CLK_DIV` clocks it issues exactly one sample into the chain with a one-cycle advance strobe. After the chain latency it captures the filtered result into a valid/ready output register, and it flags source underruns and sink overruns.

## Interface
- `DW`, 16: sample width, signed two's complement.
- `CLK_DIV`, 2083: clocks per sample period (100 MHz / 48 kHz). Must be ≥ `CHAIN_LAT`+3.
- `CHAIN_LAT`, 1: cycles from the `chain_ce` cycle to a valid `chain_y`. Must be ≥ 1.
- `CNT_W`, 16: width of the event counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable.
- `s_valid` in 1, `s_ready` out 1, `s_data` in DW: input sample stream.
- `chain_x` out DW: registered sample to the chain.
- `chain_ce` out 1: one-cycle advance strobe to the chain.
- `chain_y` in DW: chain output.
- `m_valid` out 1, `m_ready` in 1, `m_data` out DW: filtered output stream.
- `busy` out 1: a sample is in flight (state WAIT_LAT).
- `underrun_cnt` out CNT_W: count of ticks where no input sample was available.
- `overrun_cnt` out CNT_W: count of unconsumed outputs that were overwritten.

## Operation
- Reset values: all outputs 0, state IDLE, tick counter 0, latency counter 0.
- Tick counter:
  - Counts 0..`CLK_DIV`-1 while state is not IDLE, wrapping to 0.
  - `tick` is asserted when the count equals `CLK_DIV`-1.
  - The counter is held at 0 in IDLE.
- FSM states and transitions:
  - IDLE: on `en`=1, go to WAIT_TICK with the counter at 0.
  - WAIT_TICK, when `tick`:
    - `s_ready` is combinational: `tick` AND state==WAIT_TICK. It is high only in that cycle.
    - If `s_valid`=1, the sample is accepted and `chain_x` <= `s_data`.
    - Otherwise `chain_x` <= 0 and `underrun_cnt` increments.
    - In both cases `chain_ce` <= 1 for one cycle, the latency counter is loaded with `CHAIN_LAT`, and the FSM goes to WAIT_LAT.
  - WAIT_TICK, when `en`=0 and no `tick`: go to IDLE.
  - WAIT_LAT:
    - The latency counter decrements each cycle.
    - When it reaches 0: `m_data` <= `chain_y` and `m_valid` <= 1.
    - Next state is WAIT_TICK if `en`=1, else IDLE.
    - `en` is ignored while in WAIT_LAT; an in-flight sample always completes.
- Output register:
  - `m_valid` clears on `m_valid`&&`m_ready`.
  - A capture while `m_valid`=1 and `m_ready`=0 overwrites `m_data` and increments `overrun_cnt`.
  - A capture in the same cycle as an accepted transfer keeps `m_valid`=1 and is not an overrun.
- Counters saturate at all-ones and never wrap. They are cleared only by reset.
- `chain_x` holds its value between strobes.

## Timing
- Let T be the tick cycle (`s_ready` high).
- `chain_ce` and the new `chain_x` are visible in cycle T+1.
- `chain_y` is sampled at the end of cycle T+1+`CHAIN_LAT`.
- `m_valid` and `m_data` are visible from cycle T+2+`CHAIN_LAT`.
- Period: exactly one `chain_ce` per `CLK_DIV` cycles while running. Consecutive strobes are exactly `CLK_DIV` cycles apart.
- After `en` rises in IDLE, the first `tick` occurs `CLK_DIV` cycles after the FSM enters WAIT_TICK.
- Asserting `rst_n`=0 mid-sample aborts immediately. No `chain_ce` and no `m_valid` occur until restarted.

## Configuration
- Macro: `BIRDSONG_SCHED_STATS_EN`.
- Defined: the underrun and overrun counters are implemented as specified.
- Undefined: the counters are not built; `underrun_cnt` and `overrun_cnt` are tied to 0. All other behaviour is identical.

## Structure
- Package `birdsong_pkg` holds:
  - `DW` and the default `CLK_DIV`/`CHAIN_LAT` constants.
  - The sample typedef (signed [DW-1:0]).
  - The FSM state enum {IDLE, WAIT_TICK, WAIT_LAT}.
- Sub-module `birdsong_tick_gen` is the divide-by-`CLK_DIV` counter.
  - Inputs: `clk`, `rst_n`, `run`.
  - Output: `tick`.
  - The counter clears when `run`=0.
- The FSM, latency counter, output register and statistics live in the top.

## Test plan
All scenarios use `CLK_DIV`=8 and `CHAIN_LAT`=3, with a stub chain where `y` equals the `x` captured at `ce`, delayed 3 cycles.
- Reset: with `rst_n`=0, all outputs are 0. After release with `en`=0 for 20 cycles, there is no `chain_ce` and no `s_ready`.
- Steady stream: `en`=1, `s_valid`=1, `s_data`=0x1234, `m_ready`=1.
  - `s_ready` pulses at cycles 8, 16, 24 after WAIT_TICK entry.
  - `chain_ce` pulses one cycle later.
  - `m_valid` rises 5 cycles after each `s_ready`, with `m_data`=0x1234.
- Underrun: `s_valid`=0 at one tick gives `chain_x`=0x0000, one `chain_ce` pulse, and `underrun_cnt`=1.
- Overrun: `m_ready`=0 across 3 captures with inputs 0x0001, 0x0002, 0x0003.
  - `overrun_cnt`=2 and `m_data`=0x0003.
  - A later `m_ready` clears `m_valid` after one transfer.
- `en` dropped in WAIT_LAT: that sample still reaches `m_valid`, the FSM then enters IDLE, and there are no further `chain_ce` pulses for 30 cycles.
- Saturation with `CNT_W`=2: 5 underruns give `underrun_cnt`=3. With the macro undefined, both counters read 0 throughout.
